mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the instruction-fetch requester (IF, read-only) and the data requester (MEM stage, read/write).
- Sits between the IF/MEM stages and the unified memory model.
- Arbitrates with data priority plus an anti-starvation counter, sequences one outstanding transaction at a time, supports fetch kill on redirect, and times out hung accesses.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while IF is waiting; after that, IF wins the next arbitration.
- TIMEOUT, 64: maximum cycles in a BUSY state without mem_ack before an error response is returned.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous assert, active-low (0 = reset)
- if_req  in  1  fetch request; held until if_ack, or withdrawn only via if_kill
- if_addr  in  AW  fetch address; stable while if_req
- if_kill  in  1  discard the pending or in-flight fetch (branch redirect)
- if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  out  DW  fetched word
- if_err  out  1  qualifies if_ack: fetch timed out
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_ack  out  1  one-cycle pulse: data access complete
- d_rdata  out  DW  load data (undefined on stores)
- d_err  out  1  qualifies d_ack: data access timed out
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_ack  in  1  memory completion pulse; at least 1 cycle after mem_req rises
- mem_rdata  in  DW  read data, valid with mem_ack

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, acks, errs, rdata); starve and timeout counters 0; kill_pending 0.
- All outputs are registered.
- States:
  - IDLE: arbitrate. d_req and not (if_req and starve_cnt==STARVE_LIMIT) → BUSY_D. Else if_req and not if_kill → BUSY_IF. Else stay.
  - BUSY_D, BUSY_IF: mem_req=1; mem_we/mem_addr/mem_wdata were latched on the grant edge and stay stable. On mem_ack → RESP. On timeout_cnt==TIMEOUT-1 without mem_ack → RESP with err=1.
  - RESP: one cycle. Pulse the granted requester's ack with rdata (or err), except a killed fetch, which gets no ack. Then → IDLE.
- Latency: request seen in IDLE at cycle N → mem_req=1 at N+1. mem_ack at M → ack at M+1 → IDLE at M+2. Minimum request-to-ack is 3 cycles.
- Requesters drop or replace req on the edge after ack. The arbiter does not look at req during RESP, so a completed request cannot be re-granted.
- Starve counter:
  - Increments on each data grant made while if_req=1.
  - Resets to 0 on any IF grant, or when if_req=0 in IDLE.
  - Saturates at STARVE_LIMIT.
- Kill:
  - if_kill in IDLE suppresses the fetch grant that cycle.
  - if_kill in BUSY_IF sets kill_pending. The memory transaction still completes (mem_req is never dropped early). In RESP, if_ack is suppressed, then kill_pending is cleared.
  - if_kill during BUSY_D or RESP-of-data has no effect.
- Timeout counter:
  - Clears on entry to a BUSY state and increments each BUSY cycle.
  - On timeout, mem_req drops in RESP. A late mem_ack arriving while IDLE or RESP is ignored.
- Simultaneous d_req and if_req: data wins unless starve_cnt==STARVE_LIMIT.
- mem_ack outside BUSY states is ignored.
- Reset mid-transaction: immediate return to IDLE, mem_req=0, no ack issued.

Decomposition:
- Shared package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, BUSY_IF, BUSY_D, RESP};
  - grant_t enum {GNT_NONE, GNT_IF, GNT_D};
  - default STARVE_LIMIT and TIMEOUT localparams.
- One sub-module, arb_timeout_timer: clear/enable inputs, expired output, width $clog2(TIMEOUT). Reused later by the bus bridge.

Test Plan:
- Single load: d_req, d_addr=0x100, memory acks 2 cycles after mem_req with 0xDEADBEEF → mem_req 1 cycle after d_req; d_ack + d_rdata=0xDEADBEEF 1 cycle after mem_ack; exactly one d_ack.
- Contention: if_req and d_req both held high, d_req re-asserted immediately after each d_ack → grants follow D,D,D,D,IF,D,D,D,D,IF for STARVE_LIMIT=4.
- Store: d_we=1, d_addr=0x20, d_wdata=0x12345678 → mem_we=1 with mem_addr=0x20 and mem_wdata=0x12345678, stable until mem_ack.
- Kill in flight: fetch granted, if_kill pulsed 1 cycle later, memory acks after 3 cycles → mem_req held until mem_ack, no if_ack, IDLE 2 cycles after mem_ack, next d_req granted.
- Timeout: fetch granted, mem_ack never arrives, TIMEOUT=64 → mem_req high 64 cycles; if_ack with if_err=1; a late mem_ack at cycle 70 is ignored.
- Reset: rst=0 asserted mid-BUSY_D → all outputs 0 asynchronously, before the next clock edge; after release, the first request behaves as in the single-load case.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter and its helpers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_D    = 2'd2
    } grant_t;

    localparam int DEF_STARVE_LIMIT = 4;
    localparam int DEF_TIMEOUT      = 64;

endpackage

// File: rtl/arb_timeout_timer.sv
// Busy-cycle watchdog: counts enabled cycles since the last clear and flags
// the TIMEOUT-th one. Saturates there so a stuck enable cannot wrap.
module arb_timeout_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between fetch (read-only) and data
// requesters: data priority with anti-starvation, fetch kill, access timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int AW           = 32,
    parameter int DW           = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_kill,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    output logic          if_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output arb_state_t    dbg_state
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_t    state_q, state_d;
    grant_t        gnt;
    logic [SW-1:0] starve_q, starve_d;
    logic          kill_q, kill_d;
    logic          busy, expired, done;

    logic          mem_req_d, mem_we_d, if_ack_d, if_err_d, d_ack_d, d_err_d;
    logic [AW-1:0] mem_addr_d;
    logic [DW-1:0] mem_wdata_d, if_rdata_d, d_rdata_d;

    assign busy      = (state_q == BUSY_IF) || (state_q == BUSY_D);
    assign done      = busy && (mem_ack || expired);
    assign dbg_state = state_q;

    arb_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!busy),
        .enable  (busy),
        .expired (expired)
    );

    // Data wins unless the fetch side has already lost STARVE_LIMIT times.
    always_comb begin
        gnt = GNT_NONE;
        if (d_req && !(if_req && starve_q == STARVE_MAX)) begin
            gnt = GNT_D;
        end else if (if_req && !if_kill) begin
            gnt = GNT_IF;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            kill_q    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            kill_q    <= kill_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            if_ack    <= if_ack_d;
            if_err    <= if_err_d;
            if_rdata  <= if_rdata_d;
            d_ack     <= d_ack_d;
            d_err     <= d_err_d;
            d_rdata   <= d_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (gnt == GNT_D) begin
                    state_d = BUSY_D;
                end else if (gnt == GNT_IF) begin
                    state_d = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (done) begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; acks are computed on the edge
    // entering RESP so they are visible for exactly the RESP cycle.
    always_comb begin
        starve_d    = starve_q;
        kill_d      = kill_q;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if_ack_d    = 1'b0;
        if_err_d    = 1'b0;
        if_rdata_d  = if_rdata;
        d_ack_d     = 1'b0;
        d_err_d     = 1'b0;
        d_rdata_d   = d_rdata;
        case (state_q)
            IDLE: begin
                if (!if_req) begin
                    starve_d = '0;
                end
                if (gnt == GNT_D) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    if (if_req && starve_q != STARVE_MAX) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (gnt == GNT_IF) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    starve_d    = '0;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (state_q == BUSY_IF && if_kill) begin
                    kill_d = 1'b1;
                end
                if (done) begin
                    mem_req_d = 1'b0;
                    if (state_q == BUSY_D) begin
                        d_ack_d   = 1'b1;
                        d_err_d   = !mem_ack;
                        d_rdata_d = mem_ack ? mem_rdata : '0;
                    end else if (!(kill_q || if_kill)) begin
                        if_ack_d   = 1'b1;
                        if_err_d   = !mem_ack;
                        if_rdata_d = mem_ack ? mem_rdata : '0;
                    end
                end
            end
            default: begin
                kill_d = 1'b0;
            end
        endcase
    end

endmodule
